div16_mc: RTL and testbench

Multicycle 16-bit integer divider for the simplified multicycle 16-bit RISC-V processor. It computes quotient and remainder, signed or unsigned, by restoring division: one subtract-and-shift step per clock over 16 cycles. It is the subtract-side counterpart of the PC/ALU adder datapath. The execute-stage controller starts it with a start/done handshake and stalls while it is busy.

---
 rtl/div16_mc_pkg.sv | 13 +
 rtl/div16_mc_sub17c.sv | 15 +
 rtl/div16_mc.sv | 83 ++++++++
 tb/tb_div16_mc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div16_mc_pkg.sv
// div16_mc_pkg: shared widths, FSM encoding and two's-complement helper for the multicycle divider
package div16_mc_pkg;
   localparam int DATA_W = 16;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;
   function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
      return ~x + DATA_W'(1);
   endfunction
endpackage

// File: rtl/div16_mc_sub17c.sv
// sub17c: stateless 17-bit ripple subtractor a + ~b + 1 built from 1-bit full-adder cells
module sub17c (
   input  logic [16:0] a,
   input  logic [16:0] b,
   output logic [16:0] diff,
   output logic        borrow
);
   logic [17:0] c;
   assign c[0] = 1'b1;
   for (genvar i = 0; i < 17; i++) begin : g_fa
      assign diff[i]  = a[i] ^ ~b[i] ^ c[i];
      assign c[i + 1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
   end
   assign borrow = ~c[17];
endmodule

// File: rtl/div16_mc.sv
// div16_mc: 16-bit signed/unsigned restoring divider, one quotient bit per clock, start/done handshake
module div16_mc
   import div16_mc_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div0
);
   state_t state, state_nxt;
   logic [WIDTH-1:0] a, d, nxt_a, q_fix, r_fix;
   logic [WIDTH:0] p, p_shift, diff, nxt_p;
   logic [CNT_W-1:0] cnt;
   logic neg_q, neg_r, zero, borrow, take;
   logic unused_p_msb;
   sub17c u_sub (
      .a     (p_shift),
      .b     ({1'b0, d}),
      .diff  (diff),
      .borrow(borrow)
   );
   // P never exceeds 16 bits between steps; only P' uses the 17th bit
   assign unused_p_msb = p[WIDTH];
   assign busy = state == RUN;
   assign done = state == FIN;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = IDLE;
      p_shift = {p[WIDTH-1:0], a[WIDTH-1]};
      take = ~borrow;
      nxt_p = take ? diff : p_shift;
      nxt_a = {a[WIDTH-2:0], take};
      q_fix = (neg_q & ~zero) ? neg(nxt_a) : nxt_a;
      r_fix = neg_r ? neg(nxt_p[WIDTH-1:0]) : nxt_p[WIDTH-1:0];
      state_nxt = state == IDLE ? (start ? RUN : IDLE)
                : state == RUN ? (cnt == '0 ? FIN : RUN)
                : IDLE;
   end
   // Results are written on the final RUN edge so they are valid the cycle done rises
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a <= '0;
         d <= '0;
         p <= '0;
         cnt <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         zero <= 1'b0;
         quotient <= '0;
         remainder <= '0;
         div0 <= 1'b0;
      end else if (state == IDLE && start) begin
         a <= (is_signed & dividend[WIDTH-1]) ? neg(dividend) : dividend;
         d <= (is_signed & divisor[WIDTH-1]) ? neg(divisor) : divisor;
         p <= '0;
         cnt <= '1;
         neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_r <= is_signed & dividend[WIDTH-1];
         zero <= divisor == '0;
      end else if (state == RUN) begin
         a <= nxt_a;
         p <= nxt_p;
         cnt <= cnt - CNT_W'(1);
         if (cnt == '0) begin
            quotient <= q_fix;
            remainder <= r_fix;
            div0 <= zero;
         end
      end
   end
endmodule

// File: tb/tb_div16_mc.sv
// tb_div16_mc: directed scoreboard bench for the multicycle divider
module tb_div16_mc;
   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
   logic [15:0] dividend = '0, divisor = '0;
   logic busy, done, div0;
   logic [15:0] quotient, remainder;
   exp_t sb[$];
   int done_at[$];
   int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0;

   div16_mc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div0(div0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic exp_t model(input logic [15:0] dd, input logic [15:0] dv, input logic sg);
      exp_t e;
      int x, y;
      if (dv == 16'h0000) begin
         e.q = 16'hFFFF;
         e.r = dd;
         e.z = 1'b1;
         return e;
      end
      e.z = 1'b0;
      if (sg) begin
         x = int'($signed(dd));
         y = int'($signed(dv));
         e.q = 16'(x / y);
         e.r = 16'(x % y);
      end else begin
         e.q = dd / dv;
         e.r = dd % dv;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (done) begin : chk_done
         exp_t e;
         done_cnt++;
         done_at.push_back(cyc);
         check("pending_op_at_done", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div0", div0, e.z);
            check("busy_low_at_done", busy, 0);
         end
      end
   end

   task automatic op(input logic [15:0] dd, input logic [15:0] dv, input logic sg);
      int lat;
      @(negedge clk);
      dividend = dd;
      divisor = dv;
      is_signed = sg;
      start = 1'b1;
      @(posedge clk);
      sb.push_back(model(dd, dv, sg));
      #1 start = 1'b0;
      check("busy_after_accept", busy, 1);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 17);
   endtask

   initial begin
      int t0, k, n0, dc;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_div0", div0, 0);
      rst_n = 1'b1;

      op(16'd100, 16'd7, 1'b0);
      op(16'hFF9C, 16'd7, 1'b1);
      op(16'd100, 16'hFFF9, 1'b1);
      op(16'h1234, 16'h0000, 1'b0);
      op(16'h8001, 16'h0000, 1'b1);
      op(16'h8000, 16'hFFFF, 1'b1);
      op(16'hFFFF, 16'h0001, 1'b0);
      op(16'hFF9C, 16'd7, 1'b0);
      for (int i = 0; i < 6; i++)
         op(16'($urandom), 16'($urandom_range(1, 65535)), 1'($urandom_range(0, 1)));

      // start pulse mid-operation with different operands must not disturb or queue
      @(negedge clk);
      dividend = 16'd100;
      divisor = 16'd7;
      is_signed = 1'b0;
      start = 1'b1;
      @(posedge clk);
      sb.push_back(model(16'd100, 16'd7, 1'b0));
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      dividend = 16'h5555;
      divisor = 16'd3;
      is_signed = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("done_after_ignored_start", done, 1);
      repeat (20) @(negedge clk);
      check("ignored_start_not_queued", busy, 0);

      // start held high: accepts at edges 0 and 18 only
      dividend = 16'd1000;
      divisor = 16'd33;
      is_signed = 1'b0;
      start = 1'b1;
      t0 = cyc + 1;
      n0 = done_at.size();
      sb.push_back(model(16'd1000, 16'd33, 1'b0));
      sb.push_back(model(16'd1000, 16'd33, 1'b0));
      repeat (36) @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      check("held_start_op_count", done_at.size() - n0, 2);
      if (done_at.size() - n0 == 2) begin
         check("held_done_cycle_1", done_at[n0] - t0 + 1, 17);
         check("held_done_cycle_2", done_at[n0 + 1] - t0 + 1, 35);
      end

      // reset during RUN discards the operation
      @(negedge clk);
      dividend = 16'd500;
      divisor = 16'd9;
      is_signed = 1'b0;
      start = 1'b1;
      @(posedge clk);
      sb.push_back(model(16'd500, 16'd9, 1'b0));
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_quotient", quotient, 0);
      check("midrst_remainder", remainder, 0);
      check("midrst_div0", div0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dc = done_cnt;
      repeat (25) @(negedge clk);
      check("no_done_after_reset", done_cnt, dc);
      op(16'd500, 16'd9, 1'b0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end
endmodule
